// File: rtl/pattern_scan_engine_pkg.sv
// Shared types and helpers for the pattern scan engine.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pattern_scan_engine_if.sv
// Control, memory-port and result signals of the pattern scan engine.
interface pattern_scan_engine_if #(
    parameter int DW = 8,
    parameter int PW = 5,
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [PW-1:0] pattern;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt_inbyte;
    logic [CW-1:0] cnt_words;
    logic [CW-1:0] cnt_cross;

    // Engine side: it masters the memory port and reports results.
    modport master (
        input  start, base_addr, pattern, mem_rdata,
        output mem_rd_en, mem_addr, busy, done,
               cnt_inbyte, cnt_words, cnt_cross
    );

    // Host / memory side.
    modport slave (
        output start, base_addr, pattern, mem_rdata,
        input  mem_rd_en, mem_addr, busy, done,
               cnt_inbyte, cnt_words, cnt_cross
    );
endinterface

// File: rtl/pattern_window_match.sv
// Combinational window matcher: counts pattern hits in one word and across
// the boundary with the previous word's tail bits.
module pattern_window_match
    import pattern_scan_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 5,
    localparam int NW = cnt_width(DW)
) (
    input  logic [DW+PW-2:0] ext,
    input  logic [PW-1:0]    pattern,
    input  logic             first_word,
    output logic [NW-1:0]    inword_cnt,
    output logic [NW-1:0]    cross_cnt
);

    localparam int unsigned LAST_IN = DW - PW;

    // Window i ends at ext bit i; i <= LAST_IN stays inside the word.
    always_comb begin
        inword_cnt = '0;
        cross_cnt  = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (ext[i +: PW] == pattern) begin
                if (i <= LAST_IN) begin
                    inword_cnt = inword_cnt + NW'(1);
                end
                if (!first_word || (i <= LAST_IN)) begin
                    cross_cnt = cross_cnt + NW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pattern_scan_engine.sv
// Streams NBYTES words from memory and counts in-word, per-word and
// bitstream-wide occurrences of a PW-bit pattern.
module pattern_scan_engine
    import pattern_scan_pkg::*;
#(
    parameter int DW     = 8,
    parameter int PW     = 5,
    parameter int NBYTES = 32,
    parameter int AW     = 8,
    parameter int CW     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pattern_scan_engine_if.master bus
);

    localparam int IW = cnt_width(NBYTES - 1);
    localparam int NW = cnt_width(DW);

    if (PW < 2 || PW > DW) begin : g_pw_check
        $error("pattern_scan_engine: PW must satisfy 2 <= PW <= DW");
    end
    if (NBYTES < 1) begin : g_len_check
        $error("pattern_scan_engine: NBYTES must be at least 1");
    end
    if (CW < 31 && (NBYTES * DW) >= (1 << CW)) begin : g_cw_check
        $error("pattern_scan_engine: CW too narrow for NBYTES*DW");
    end

    scan_state_t state;
    scan_state_t state_nxt;

    logic [AW-1:0]    addr;
    logic [IW-1:0]    rd_idx;
    logic             rd_pending;
    logic             first_word;
    logic [PW-1:0]    pat_q;
    logic [PW-2:0]    carry;
    logic [CW-1:0]    cnt_in;
    logic [CW-1:0]    cnt_w;
    logic [CW-1:0]    cnt_x;
    logic [DW+PW-2:0] ext;
    logic [NW-1:0]    inword_cnt;
    logic [NW-1:0]    cross_cnt;
    logic             start_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    if (rd_idx == IW'(NBYTES - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd_en = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        start_acc     = 1'b0;
        case (state)
            IDLE:    start_acc = bus.start;
            READ: begin
                bus.mem_rd_en = 1'b1;
                bus.busy      = 1'b1;
            end
            DRAIN:   bus.busy = 1'b1;
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign ext = {carry, bus.mem_rdata};

    pattern_window_match #(
        .DW (DW),
        .PW (PW)
    ) u_match (
        .ext        (ext),
        .pattern    (pat_q),
        .first_word (first_word),
        .inword_cnt (inword_cnt),
        .cross_cnt  (cross_cnt)
    );

    // rd_pending tracks the read issued last cycle; reset clears it so an
    // in-flight return is never accumulated.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            rd_idx     <= '0;
            rd_pending <= 1'b0;
            first_word <= 1'b0;
            pat_q      <= '0;
            carry      <= '0;
            cnt_in     <= '0;
            cnt_w      <= '0;
            cnt_x      <= '0;
        end else begin
            rd_pending <= (state == READ);
            if (start_acc) begin
                pat_q      <= bus.pattern;
                addr       <= bus.base_addr;
                rd_idx     <= '0;
                carry      <= '0;
                first_word <= 1'b1;
                cnt_in     <= '0;
                cnt_w      <= '0;
                cnt_x      <= '0;
            end else begin
                if (state == READ) begin
                    addr   <= addr + AW'(1);
                    rd_idx <= rd_idx + IW'(1);
                end
                if (rd_pending) begin
                    cnt_in <= cnt_in + CW'(inword_cnt);
                    if (inword_cnt != '0) begin
                        cnt_w <= cnt_w + CW'(1);
                    end
                    cnt_x      <= cnt_x + CW'(cross_cnt);
                    carry      <= bus.mem_rdata[PW-2:0];
                    first_word <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_addr   = addr;
    assign bus.cnt_inbyte = cnt_in;
    assign bus.cnt_words  = cnt_w;
    assign bus.cnt_cross  = cnt_x;

endmodule

// File: doc/pattern_scan_engine.md
# pattern_scan_engine

Hardware accelerator for the sliding-bit-pattern count performed by the program-3 software. It streams `NBYTES` consecutive words from data memory and counts occurrences of a `PW`-bit pattern three ways:
- within each word only;
- words containing at least one such match;
- across the concatenated bitstream, including word boundaries.

It sits beside the core as a memory-port master with a start/done handshake, generalising the fixed 5-bit / 32-byte case to any pattern width, word width and length.

## Interface
- `DW`, 8: memory word width in bits.
- `PW`, 5: pattern width in bits. Legal range is 2 ≤ PW ≤ DW (elaboration assertion).
- `NBYTES`, 32: number of words scanned. Must be ≥ 1.
- `AW`, 8: memory address width.
- `CW`, 16: count width. Elaboration assertion: NBYTES*DW < 2^CW.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `base_addr` in AW: address of word 0; latched at start.
- `pattern` in PW: pattern to search for; latched at start.
- `mem_rd_en` out 1: read strobe.
- `mem_addr` out AW: read address.
- `mem_rdata` in DW: read data; valid exactly one cycle after the strobe.
- `busy` out 1: high from the cycle after start is accepted until `done`, inclusive of the `done` cycle.
- `done` out 1: one-cycle pulse when all counts are final.
- `cnt_inbyte` out CW: matches fully inside one word.
- `cnt_words` out CW: words with ≥ 1 in-word match.
- `cnt_cross` out CW: matches anywhere in the bitstream.

## Operation
- **Bitstream order.** Word 0 comes first. Within a word, the MSB comes first.
- **Window positions.** Windows start at bit positions 0 .. NBYTES*DW−PW, i.e. NBYTES*DW−PW+1 windows in total (252 for the default parameters).
- **State machine: IDLE → READ → DRAIN → DONE → IDLE.**
  - **IDLE:** `start`=1 latches `pattern` and `base_addr`, clears all three counts and the carry register, then goes to READ.
  - **READ:** lasts NBYTES cycles. `mem_rd_en`=1 with `mem_addr`=base_addr+k for k = 0..NBYTES−1. The address wraps modulo 2^AW.
  - **DRAIN:** one cycle, to absorb the final read return.
  - **DONE:** one cycle with `done`=1, then back to IDLE.
- **Per-word accumulation.** Performed in the cycle each read returns.
  - Form ext = {carry[PW−2:0], word}, which is DW+PW−1 bits wide.
  - In-word matches are the windows ext[i+PW−1:i] for i = 0..DW−PW. Add their popcount to `cnt_inbyte`.
  - If that popcount is non-zero, increment `cnt_words`.
  - Cross matches:
    - word 0: the same DW−PW+1 windows as the in-word check;
    - every later word: all DW windows ending inside that word.
  - Add the cross popcount to `cnt_cross`.
  - Update carry to word[PW−2:0].
- **Result holding.** Counts hold their value after `done` until the next accepted `start`.
- **Wrap-around.** No count saturation is needed because the parameter assertion guarantees no count can wrap.
- **Boundary rules:**
  - `start` while not IDLE is ignored. `pattern` and `base_addr` changes mid-scan are ignored.
  - `start` held high through DONE: the next scan is accepted in the first IDLE cycle, not in the DONE cycle.
  - `reset` at any point: next cycle the block is in IDLE with all counts 0, `done`=0, `busy`=0, `mem_rd_en`=0 and `mem_addr`=0. Any read return still in flight is discarded.
  - NBYTES=1: cross count equals in-word count.

## Timing
- **Reset values:** all outputs are 0.
- **Cycle-level sequence.** Take cycle 0 as the cycle `start` is sampled in IDLE.
  - Cycles 1..NBYTES: `mem_rd_en`=1.
  - Cycles 2..NBYTES+1: data is accumulated.
  - Cycle NBYTES+2: `done`=1, and the counts are final in that same cycle.
- **Latency:** start to done is NBYTES+2 cycles, i.e. 34 cycles at default parameters.
- **Minimum start-to-start:** NBYTES+3 cycles.
- **Read port:** one read per cycle, with no stall or backpressure.

## Structure
- **Shared package `pattern_scan_pkg`:**
  - state enum `scan_state_t` (IDLE, READ, DRAIN, DONE);
  - a count-width helper function.
- **Sub-module `pattern_window_match`:** combinational.
  - Inputs: ext vector, pattern, first-word flag.
  - Outputs: in-word popcount and cross popcount.
  - Parametrised by `DW` and `PW`.
- **Top module `pattern_scan_engine`:** holds the FSM, address counter, word index, carry register and accumulators.

## Test plan
1. All words 0x00, pattern 5'b00000, default parameters → `cnt_inbyte`=128, `cnt_words`=32, `cnt_cross`=252; `done` asserted exactly 34 cycles after `start`.
2. Word 0 = 0xF8, all others 0x00, pattern 5'b11111 → 1 / 1 / 1.
3. Word 0 = 0x03, word 1 = 0xE0, others 0x00, pattern 5'b11111 → 0 / 0 / 1 (boundary-only match).
4. `base_addr`=0xF0 with AW=8 → reads 0xF0..0xFF then 0x00..0x0F. `start` pulsed during READ → ignored, and `done` appears only once.
5. `reset` asserted at cycle 10 of a scan → next cycle all outputs 0 and FSM in IDLE. A fresh scan started afterwards produces correct counts.
6. Random memory contents and patterns, for (DW, PW, NBYTES) = (8,5,32), (8,2,1), (16,7,20) and (8,8,32), each 200 scans → counts match a software model of the three definitions.
